// File: rtl/bp_nonsynth_cosim_pkg.sv
// bp_nonsynth_cosim_pkg: shared state, record layout and width helpers for the cosim commit scheduler
package bp_nonsynth_cosim_pkg;

    typedef enum logic [2:0] {
        e_reset,
        e_init,
        e_wait_init,
        e_run,
        e_drain,
        e_done
    } bp_cosim_sched_state_e;

    localparam int cosim_vaddr_width_gp = 39;
    localparam int cosim_dword_width_gp = 64;

    // Commit record as seen on core_data_i / step_data_o, MSB first
    typedef struct packed {
        logic                            commit_v;
        logic                            interrupt_v;
        logic [cosim_vaddr_width_gp-1:0] pc;
        logic [31:0]                     instr;
        logic [cosim_dword_width_gp-1:0] wdata;
        logic [cosim_dword_width_gp-1:0] cause;
    } bp_cosim_commit_s;

    function automatic int bp_cosim_rec_width(input int vaddr_width, input int dword_width);
        return 2 + vaddr_width + 32 + 2 * dword_width;
    endfunction

    // Hart id width that stays legal for a single core
    function automatic int bp_cosim_id_width(input int num_core);
        return (num_core > 1) ? $clog2(num_core) : 1;
    endfunction

endpackage

// File: rtl/bp_nonsynth_cosim_rr_arb.sv
// bp_nonsynth_cosim_rr_arb: round-robin arbiter with one-hot grant and yumi-advanced pointer
//   clk_i, reset_i : clock, async active-low reset
//   i_v            : per-requester valid
//   i_yumi         : grant was taken this cycle; advance priority past the winner
//   o_grant        : one-hot grant (combinational from i_v and the pointer)
//   o_id, o_gv     : index of the granted requester and whether any was granted
module bp_nonsynth_cosim_rr_arb
    import bp_nonsynth_cosim_pkg::*;
#(
    parameter  int num_core_p  = 4,
    localparam int id_width_lp = bp_cosim_id_width(num_core_p)
)(
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [num_core_p-1:0]  i_v,
    input  logic                   i_yumi,
    output logic [num_core_p-1:0]  o_grant,
    output logic [id_width_lp-1:0] o_id,
    output logic                   o_gv
);

    logic [id_width_lp-1:0] r_ptr;
    logic [id_width_lp-1:0] w_cand;

    // Scan from farthest to nearest so the requester closest to r_ptr wins last
    always_comb begin
        o_grant = '0;
        o_id    = r_ptr;
        o_gv    = 1'b0;
        w_cand  = r_ptr;
        for (int k = num_core_p - 1; k >= 0; k--) begin
            w_cand = id_width_lp'((int'(r_ptr) + k) % num_core_p);
            if (i_v[w_cand]) begin
                o_gv = 1'b1;
                o_id = w_cand;
            end
        end
        o_grant[o_id] = o_gv;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)
            r_ptr <= '0;
        else if (i_yumi)
            r_ptr <= (int'(o_id) == num_core_p - 1) ? '0 : o_id + 1'b1;
    end

endmodule

// File: rtl/bp_nonsynth_cosim_sched.sv
// bp_nonsynth_cosim_sched: serializes per-core commit records onto one cosim step channel
//   clk_i, reset_i        : clock, async active-low reset
//   en_i                  : cosim enable, only looked at in e_reset
//   instr_limit_i         : per-core pass threshold, 0 disables pass
//   core_v_i/core_data_i  : per-core records; core_ready_o is the one-hot accept
//   init_v_o/init_done_i  : one-shot simulator init handshake
//   step_v_o/step_core_o/step_data_o/step_yumi_i/step_fail_i : single-entry step channel
//   pass_o, fail_o, done_o: sticky status
// Optional: COSIM_SCHED_WATCHDOG_EN adds watchdog_cycles_p and stall_o; a run with no
// transfer for watchdog_cycles_p cycles fails.
module bp_nonsynth_cosim_sched
    import bp_nonsynth_cosim_pkg::*;
#(
    parameter  int num_core_p        = 4,
    parameter  int vaddr_width_p     = 39,
    parameter  int dword_width_p     = 64,
    parameter  int max_instr_p       = 2**30,
`ifdef COSIM_SCHED_WATCHDOG_EN
    parameter  int watchdog_cycles_p = 100000,
`endif
    localparam int rec_width_lp      = bp_cosim_rec_width(vaddr_width_p, dword_width_p),
    localparam int id_width_lp       = bp_cosim_id_width(num_core_p)
)(
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             en_i,
    input  logic [31:0]                      instr_limit_i,
    input  logic [num_core_p-1:0]            core_v_i,
    input  logic [num_core_p*rec_width_lp-1:0] core_data_i,
    output logic [num_core_p-1:0]            core_ready_o,
    output logic                             init_v_o,
    input  logic                             init_done_i,
    output logic                             step_v_o,
    output logic [id_width_lp-1:0]           step_core_o,
    output logic [rec_width_lp-1:0]          step_data_o,
    input  logic                             step_yumi_i,
    input  logic                             step_fail_i,
    output logic                             pass_o,
    output logic                             fail_o,
    output logic                             done_o
`ifdef COSIM_SCHED_WATCHDOG_EN
    ,output logic                            stall_o
`endif
);

    localparam int cnt_width_lp = $clog2(max_instr_p + 1);

    bp_cosim_sched_state_e   r_state, w_state_n;
    logic [num_core_p-1:0]   w_grant;
    logic [id_width_lp-1:0]  w_gid, r_core;
    logic                    w_gv, w_open, w_xfer, w_commit, w_pass, w_fail;
    logic                    r_v, r_pass, r_fail;
    logic [rec_width_lp-1:0] w_rec, r_data;
    logic [cnt_width_lp-1:0] r_cnt [num_core_p];

    bp_nonsynth_cosim_rr_arb #(.num_core_p(num_core_p)) u_arb (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .i_v     (core_v_i),
        .i_yumi  (w_xfer),
        .o_grant (w_grant),
        .o_id    (w_gid),
        .o_gv    (w_gv)
    );

    // The output register can take a record when empty or being drained this cycle
    assign w_open       = (r_state == e_run) && (!r_v || step_yumi_i);
    assign core_ready_o = w_grant & {num_core_p{w_open}};
    assign w_xfer       = w_open && w_gv;
    assign w_rec        = core_data_i[int'(w_gid) * rec_width_lp +: rec_width_lp];
    assign w_commit     = w_rec[rec_width_lp-1] && (w_rec[rec_width_lp-3 -: vaddr_width_p] != '0);

    assign step_v_o    = r_v;
    assign step_core_o = r_core;
    assign step_data_o = r_data;
    assign pass_o      = r_pass;
    assign fail_o      = r_fail;

    always_comb begin
        w_pass = (r_state == e_run) && (instr_limit_i != '0);
        for (int i = 0; i < num_core_p; i++)
            if (64'(r_cnt[i]) < 64'(instr_limit_i))
                w_pass = 1'b0;
    end

`ifdef COSIM_SCHED_WATCHDOG_EN
    localparam int wd_width_lp = $clog2(watchdog_cycles_p + 1);
    logic [wd_width_lp-1:0] r_wd;
    logic                   r_stall, w_timeout;

    // Fires on the cycle the idle count would reach watchdog_cycles_p
    assign w_timeout = (r_state == e_run) && !w_xfer && (int'(r_wd) == watchdog_cycles_p - 1);
    assign w_fail    = (r_state == e_run) && ((step_yumi_i && step_fail_i) || w_timeout);
    assign stall_o   = r_stall;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wd    <= '0;
            r_stall <= 1'b0;
        end else begin
            r_stall <= w_timeout;
            r_wd    <= (w_xfer || r_state != e_run) ? '0 : r_wd + 1'b1;
        end
    end
`else
    assign w_fail = (r_state == e_run) && step_yumi_i && step_fail_i;
`endif

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)
            r_state <= e_reset;
        else
            r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        init_v_o  = 1'b0;
        done_o    = 1'b0;
        case (r_state)
            e_reset:     w_state_n = en_i ? e_init : e_reset;
            e_init: begin
                init_v_o  = 1'b1;
                w_state_n = e_wait_init;
            end
            e_wait_init: w_state_n = init_done_i ? e_run : e_wait_init;
            e_run:       w_state_n = (w_fail || w_pass) ? e_drain : e_run;
            e_drain:     w_state_n = r_v ? e_drain : e_done;
            e_done:      done_o = 1'b1;
            default:     w_state_n = e_reset;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_v    <= 1'b0;
            r_core <= '0;
            r_data <= '0;
            r_pass <= 1'b0;
            r_fail <= 1'b0;
            for (int i = 0; i < num_core_p; i++)
                r_cnt[i] <= '0;
        end else begin
            if (w_xfer) begin
                r_v    <= 1'b1;
                r_core <= w_gid;
                r_data <= w_rec;
            end else if (step_yumi_i) begin
                r_v <= 1'b0;
            end
            // Fail has priority when both conditions land in the same cycle
            r_fail <= r_fail | w_fail;
            r_pass <= r_pass | (w_pass & ~w_fail);
            for (int i = 0; i < num_core_p; i++)
                if (w_xfer && w_commit && int'(w_gid) == i && int'(r_cnt[i]) < max_instr_p)
                    r_cnt[i] <= r_cnt[i] + 1'b1;
        end
    end

endmodule

// File: tb/tb_bp_nonsynth_cosim_sched.sv
// tb_bp_nonsynth_cosim_sched: randomized self-checking bench for the cosim commit scheduler
module tb_bp_nonsynth_cosim_sched;
    import bp_nonsynth_cosim_pkg::*;

    localparam int N  = 4;
    localparam int RW = 201;
    localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

    logic            clk = 1'b0, reset_i = 1'b0, en_i = 1'b0, init_done_i = 1'b0;
    logic            step_yumi_i = 1'b0, step_fail_i = 1'b0;
    logic [31:0]     instr_limit_i = '0;
    logic [N-1:0]    core_v_i = '0;
    logic [N*RW-1:0] core_data_i = '0;
    logic [N-1:0]    core_ready_o;
    logic            init_v_o, step_v_o, pass_o, fail_o, done_o;
    logic [1:0]      step_core_o;
    logic [RW-1:0]   step_data_o;

    always #5 clk = ~clk;

    bp_nonsynth_cosim_sched dut (
        .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .instr_limit_i(instr_limit_i),
        .core_v_i(core_v_i), .core_data_i(core_data_i), .core_ready_o(core_ready_o),
        .init_v_o(init_v_o), .init_done_i(init_done_i), .step_v_o(step_v_o),
        .step_core_o(step_core_o), .step_data_o(step_data_o), .step_yumi_i(step_yumi_i),
        .step_fail_i(step_fail_i), .pass_o(pass_o), .fail_o(fail_o), .done_o(done_o)
    );

    int vec = 0, err = 0;

    // Reference model: scheduler phase, rr priority, one-entry holding slot, per-core counts
    int            m_phase, m_ptr, m_hcore;
    bit            m_hv, m_pass, m_fail;
    logic [RW-1:0] m_hdata;
    int            m_cnt [N];
    logic [RW-1:0] q [N][$];
    int            tcnt [N];

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    function automatic logic [RW-1:0] mk(input bit c, input bit t, input bit zero_pc);
        bp_cosim_commit_s r;
        r.commit_v    = c;
        r.interrupt_v = t;
        r.pc          = zero_pc ? '0 : (39'({$urandom(), $urandom()}) | 39'd4);
        r.instr       = $urandom();
        r.wdata       = {$urandom(), $urandom()};
        r.cause       = {$urandom(), $urandom()};
        return r;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] g);
        for (int i = 0; i < N; i++)
            if (g[i]) return i;
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        if (m_phase != P_RUN || (m_hv && !step_yumi_i)) return '0;
        for (int k = 0; k < N; k++)
            if (core_v_i[(m_ptr + k) % N]) return N'(1) << ((m_ptr + k) % N);
        return '0;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_ptr = 0; m_hv = 0; m_hcore = 0; m_hdata = '0;
        m_pass = 0; m_fail = 0;
        for (int i = 0; i < N; i++) begin m_cnt[i] = 0; tcnt[i] = 0; q[i].delete(); end
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++)
            core_data_i[i*RW +: RW] = mk($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
    endtask

    // Apply the current inputs to the model for one rising edge, then move to the next falling edge
    task automatic tick();
        logic [N-1:0] g = exp_ready() & core_v_i;
        bit old_hv = m_hv;
        bit f = (m_phase == P_RUN) && step_yumi_i && step_fail_i;
        bit p = (m_phase == P_RUN) && (instr_limit_i != 0);
        for (int i = 0; i < N; i++)
            if (m_cnt[i] < instr_limit_i) p = 0;
        if (g != 0) begin
            int i = onehot_idx(g);
            bp_cosim_commit_s r = bp_cosim_commit_s'(core_data_i[i*RW +: RW]);
            if (r.commit_v && r.pc != 0 && m_cnt[i] < 2**30) m_cnt[i]++;
            m_ptr = (i + 1) % N; m_hv = 1; m_hcore = i; m_hdata = core_data_i[i*RW +: RW];
        end else if (step_yumi_i) begin
            m_hv = 0;
        end
        if (f) m_fail = 1;
        else if (p) m_pass = 1;
        if (m_phase == P_RUN && (f || p)) m_phase = P_DRAIN;
        else if (m_phase == P_DRAIN && !old_hv) m_phase = P_DONE;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic restart();
        reset_i = 0; en_i = 0; init_done_i = 0; core_v_i = '0;
        step_yumi_i = 0; step_fail_i = 0; instr_limit_i = '0;
        @(negedge clk);
        reset_i = 1;
        @(negedge clk);
        model_reset();
    endtask

    task automatic drive_q();
        for (int i = 0; i < N; i++) begin
            core_v_i[i] = q[i].size() != 0;
            core_data_i[i*RW +: RW] = (q[i].size() != 0) ? q[i][0] : mk(1, 0, 0);
        end
    endtask

    task automatic pop_q();
        logic [N-1:0] g = exp_ready() & core_v_i;
        if (g != 0) begin
            int i = onehot_idx(g);
            bp_cosim_commit_s r = bp_cosim_commit_s'(q[i].pop_front());
            if (r.commit_v && r.pc != 0) tcnt[i]++;
        end
    endtask

    task automatic test_reset();
        model_reset();
        reset_i = 0; core_v_i = '1;
        repeat (2) @(negedge clk);
        #1;
        vec++;
        if ({init_v_o, step_v_o, step_core_o, step_data_o, pass_o, fail_o, done_o, core_ready_o} !== '0) begin
            err++;
            $display("FAIL reset_outputs got=%h want=0", {init_v_o, step_v_o, step_core_o, step_data_o, pass_o, fail_o, done_o, core_ready_o});
        end
        reset_i = 1;
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            #1;
            vec++;
            if (init_v_o !== 1'b0 || core_ready_o !== '0) begin
                err++;
                $display("FAIL reset_idle c=%0d init_v=%b ready=%b want 0/0", c, init_v_o, core_ready_o);
            end
            @(negedge clk);
        end
        core_v_i = '0;
    endtask

    task automatic test_init();
        int hi = 0, at = -1;
        en_i = 1; core_v_i = '1; rand_data();
        for (int c = 0; c < 10 && !init_done_i; c++) begin
            #1;
            if (init_v_o === 1'b1) begin
                hi++;
                if (at < 0) begin at = c; en_i = 0; end
            end
            vec++;
            if (core_ready_o !== '0) begin
                err++;
                $display("FAIL init_ready c=%0d got=%b want=0000", c, core_ready_o);
            end
            if (at >= 0 && c == at + 3) init_done_i = 1;
            @(posedge clk);
            @(negedge clk);
        end
        init_done_i = 0; core_v_i = '0;
        vec++;
        if (at < 0 || hi != 1) begin
            err++;
            $display("FAIL init_pulse seen_at=%0d high_cycles=%0d want 1", at, hi);
        end
        model_reset();
        m_phase = P_RUN;
    endtask

    task automatic test_fairness();
        int prev = -1;
        logic [N-1:0] want;
        instr_limit_i = '0; core_v_i = '1; step_yumi_i = 1; step_fail_i = 0;
        for (int c = 0; c < 12; c++) begin
            rand_data();
            #1;
            want = N'(1) << (c % N);
            vec++;
            if (core_ready_o !== want) begin
                err++;
                $display("FAIL fair_grant c=%0d got=%b want=%b", c, core_ready_o, want);
            end
            if (prev >= 0) begin
                vec++;
                if (step_v_o !== 1'b1 || step_core_o !== 2'(prev) || step_data_o !== m_hdata) begin
                    err++;
                    $display("FAIL fair_step c=%0d v=%b core=%0d want v=1 core=%0d", c, step_v_o, step_core_o, prev);
                end
            end
            prev = c % N;
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [RW-1:0] held = m_hdata;
        step_yumi_i = 0;
        for (int c = 0; c < 5; c++) begin
            rand_data();
            core_v_i = N'($urandom_range(1, 15));
            #1;
            vec++;
            if (core_ready_o !== '0 || step_v_o !== 1'b1 || step_data_o !== held) begin
                err++;
                $display("FAIL bp_hold c=%0d ready=%b v=%b data_stable=%b want 0000/1/1", c, core_ready_o, step_v_o, step_data_o === held);
            end
            tick();
        end
        step_yumi_i = 1;
        #1;
        vec++;
        if (core_ready_o !== exp_ready() || core_ready_o === '0) begin
            err++;
            $display("FAIL bp_resume got=%b want=%b", core_ready_o, exp_ready());
        end
        tick();
        for (int c = 0; c < 40; c++) begin
            rand_data();
            core_v_i = N'($urandom_range(0, 15));
            step_yumi_i = $urandom_range(0, 1) == 1;
            #1;
            vec++;
            if (core_ready_o !== exp_ready() || step_v_o !== m_hv ||
                (m_hv && (step_core_o !== 2'(m_hcore) || step_data_o !== m_hdata))) begin
                err++;
                $display("FAIL rand_step c=%0d ready=%b want=%b v=%b want=%b core=%0d want=%0d",
                         c, core_ready_o, exp_ready(), step_v_o, m_hv, step_core_o, m_hcore);
            end
            tick();
        end
        core_v_i = '0; step_yumi_i = 0;
    endtask

    task automatic test_pass();
        bit all10;
        restart();
        test_init();
        for (int i = 0; i < N; i++) begin
            if (i == 2) repeat (3) q[i].push_back(mk(1, 0, 1));
            repeat (10) q[i].push_back(mk(1, 0, 0));
            if (i == 1) repeat (2) q[i].push_back(mk(0, 1, 0));
        end
        instr_limit_i = 10;
        for (int c = 0; c < 300 && done_o !== 1'b1; c++) begin
            drive_q();
            step_yumi_i = $urandom_range(0, 3) != 0;
            #1;
            all10 = 1;
            for (int i = 0; i < N; i++) if (tcnt[i] < 10) all10 = 0;
            vec++;
            if (core_ready_o !== exp_ready() || pass_o !== m_pass || fail_o !== 1'b0 ||
                done_o !== (m_phase == P_DONE) || (pass_o === 1'b1 && !all10)) begin
                err++;
                $display("FAIL pass_run c=%0d ready=%b want=%b pass=%b want=%b done=%b fail=%b",
                         c, core_ready_o, exp_ready(), pass_o, m_pass, done_o, fail_o);
            end
            pop_q();
            tick();
        end
        vec++;
        if (done_o !== 1'b1 || pass_o !== 1'b1 || fail_o !== 1'b0) begin
            err++;
            $display("FAIL pass_end done=%b pass=%b fail=%b want 1/1/0", done_o, pass_o, fail_o);
        end
        core_v_i = '0; step_yumi_i = 0;
    endtask

    task automatic test_fail();
        int ncons = 0;
        restart();
        test_init();
        repeat (3) q[0].push_back(mk(0, 1, 0));
        for (int i = 0; i < N; i++) q[i].push_back(mk(1, 0, 0));
        instr_limit_i = 1;
        for (int c = 0; c < 14; c++) begin
            drive_q();
            if (ncons >= 7) core_v_i = '1;
            step_yumi_i = 1;
            step_fail_i = m_hv && ncons == 6;
            #1;
            vec++;
            if (core_ready_o !== exp_ready() || fail_o !== m_fail || pass_o !== 1'b0 ||
                done_o !== (m_phase == P_DONE) || (ncons >= 7 && core_ready_o !== '0)) begin
                err++;
                $display("FAIL fail_run c=%0d ready=%b want=%b fail=%b want=%b pass=%b done=%b",
                         c, core_ready_o, exp_ready(), fail_o, m_fail, pass_o, done_o);
            end
            pop_q();
            if (m_hv) ncons++;
            tick();
        end
        vec++;
        if (fail_o !== 1'b1 || pass_o !== 1'b0 || done_o !== 1'b1) begin
            err++;
            $display("FAIL fail_end fail=%b pass=%b done=%b want 1/0/1", fail_o, pass_o, done_o);
        end
        core_v_i = '0; step_yumi_i = 0; step_fail_i = 0;
    endtask

    task automatic test_reset_midrun();
        restart();
        test_init();
        rand_data();
        core_v_i = 4'b0100; step_yumi_i = 0;
        #1;
        tick();
        core_v_i = '0;
        #1;
        vec++;
        if (step_v_o !== 1'b1 || step_core_o !== 2'd2) begin
            err++;
            $display("FAIL mid_hold v=%b core=%0d want 1/2", step_v_o, step_core_o);
        end
        #1;
        reset_i = 0;
        #1;
        vec++;
        if ({init_v_o, step_v_o, step_core_o, step_data_o, pass_o, fail_o, done_o, core_ready_o} !== '0) begin
            err++;
            $display("FAIL mid_async got=%h want=0", {init_v_o, step_v_o, step_core_o, step_data_o, pass_o, fail_o, done_o, core_ready_o});
        end
        @(negedge clk);
        reset_i = 1;
        model_reset();
        for (int c = 0; c < 2; c++) begin
            #1;
            vec++;
            if (dut.r_state !== e_reset || init_v_o !== 1'b0 || step_v_o !== 1'b0) begin
                err++;
                $display("FAIL mid_state c=%0d state=%0d init=%b v=%b want e_reset/0/0", c, dut.r_state, init_v_o, step_v_o);
            end
            @(negedge clk);
        end
        en_i = 1;
        @(posedge clk);
        @(negedge clk);
        #1;
        en_i = 0;
        vec++;
        if (init_v_o !== 1'b1) begin
            err++;
            $display("FAIL mid_reinit init_v=%b want 1", init_v_o);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_fairness();
        test_backpressure();
        test_pass();
        test_fail();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
